// File: rtl/reg_dump_scanner.sv
// Register-file dump scanner: walks a CPU debug read port and streams
// each register value out over a valid/ready link with a running signature.
module reg_dump_scanner #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    localparam logic [4:0] FIRST_SEL = 5'(FIRST_REG);
    localparam logic [4:0] LAST_SEL  = 5'(LAST_REG);

    state_t state;
    logic   xfer;

    assign xfer = out_valid && out_ready;

    // Scan sequencer: one word per SETTLE/CAPTURE/SEND round, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            reg_sel   <= 5'd0;
            out_valid <= 1'b0;
            out_idx   <= 5'd0;
            out_data  <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        reg_sel  <= FIRST_SEL;
                        checksum <= 32'd0;
                        busy     <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    out_data  <= reg_data;
                    out_idx   <= reg_sel;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        checksum  <= {checksum[30:0], checksum[31]} ^ out_data;
                        if (reg_sel == LAST_SEL) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            reg_sel <= reg_sel + 5'd1;
                            state   <= SETTLE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner: random register files and back-pressure,
// checked against a word-list/signature model of the scan.
module tb_reg_dump_scanner;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    logic        start_b;
    logic [4:0]  reg_sel_b;
    logic [31:0] reg_data_b;
    logic        out_valid_b;
    logic        out_ready_b;
    logic [4:0]  out_idx_b;
    logic [31:0] out_data_b;
    logic        busy_b;
    logic        done_b;
    logic [31:0] checksum_b;

    logic [31:0] rf [N];

    int n_cmp = 0;
    int n_bad = 0;

    assign reg_data   = rf[reg_sel];
    assign reg_data_b = rf[reg_sel_b];

    always #5 clk = ~clk;

    reg_dump_scanner u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    reg_dump_scanner #(
        .FIRST_REG (7),
        .LAST_REG  (7)
    ) u_one (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .reg_sel   (reg_sel_b),
        .reg_data  (reg_data_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_idx   (out_idx_b),
        .out_data  (out_data_b),
        .busy      (busy_b),
        .done      (done_b),
        .checksum  (checksum_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // Signature of an accepted word list: rotate left by one, then XOR.
    function automatic logic [31:0] sig_of(input logic [31:0] w[$]);
        logic [31:0] c;
        c = 32'd0;
        foreach (w[i]) c = {c[30:0], c[31]} ^ w[i];
        return c;
    endfunction

    // One scan of the default instance, starting at a negedge.
    task automatic scan(input bit rnd, input int stall_idx,
                        input int abort_idx, input bit hold,
                        input int exp_edges, input string tag);
        logic [31:0] words[$];
        logic [4:0]  held_idx;
        logic [31:0] held_data;
        int nxt;
        int edges;
        int stall;
        bit was_valid;
        bit seen_done;
        bit aborted;
        nxt = 0;
        edges = 0;
        stall = 0;
        was_valid = 1'b0;
        seen_done = 1'b0;
        aborted = 1'b0;
        held_idx = 5'd0;
        held_data = 32'd0;
        start = 1'b1;
        while (!seen_done && !aborted && edges < 2000) begin
            if (was_valid) begin
                check({tag, " hold valid"}, 32'(out_valid), 32'd1);
                check({tag, " hold idx"}, 32'(out_idx), 32'(held_idx));
                check({tag, " hold data"}, out_data, held_data);
            end
            if (abort_idx >= 0 && out_valid && int'(out_idx) == abort_idx) begin
                aborted = 1'b1;
                break;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_idx >= 0 && out_valid &&
                int'(out_idx) == stall_idx && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end
            if (out_valid && out_ready) begin
                if (nxt < N) begin
                    check({tag, " idx"}, 32'(out_idx), 32'(nxt));
                    check({tag, " data"}, out_data, rf[nxt]);
                    words.push_back(rf[nxt]);
                end else begin
                    check({tag, " extra word"}, 32'(nxt), 32'(N - 1));
                end
                nxt++;
                was_valid = 1'b0;
            end else begin
                was_valid = out_valid;
                held_idx = out_idx;
                held_data = out_data;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) seen_done = 1'b1;
        end
        if (abort_idx >= 0) begin
            check({tag, " reached abort word"}, 32'(aborted), 32'd1);
        end else begin
            check({tag, " done seen"}, 32'(seen_done), 32'd1);
            check({tag, " word count"}, 32'(nxt), 32'(N));
            if (exp_edges > 0)
                check({tag, " latency"}, 32'(edges), 32'(exp_edges));
            check({tag, " checksum"}, checksum, sig_of(words));
            check({tag, " busy at done"}, 32'(busy), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check({tag, " done one cycle"}, 32'(done), 32'd0);
            check({tag, " busy after"}, 32'(busy), 32'd0);
            check({tag, " checksum kept"}, checksum, sig_of(words));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        start_b = 1'b0;
        out_ready_b = 1'b0;
        for (int i = 0; i < N; i++) rf[i] = 32'(i);
        repeat (2) @(negedge clk);

        check("reset reg_sel", 32'(reg_sel), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_idx", 32'(out_idx), 32'd0);
        check("reset out_data", out_data, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset checksum", checksum, 32'd0);
        rst = 1'b0;

        scan(1'b0, -1, -1, 1'b0, 3 * N + 1, "ramp");
        scan(1'b0, 7, -1, 1'b0, 3 * N + 1 + 5, "stall7");

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) rf[i] = $urandom;
            scan(1'b1, -1, -1, 1'b0, 0, "random");
        end

        for (int i = 0; i < N; i++) rf[i] = 32'hFFFF_FFFF;
        scan(1'b0, -1, -1, 1'b0, 3 * N + 1, "ones");
        check("ones zero signature", checksum, 32'd0);

        for (int i = 0; i < N; i++) rf[i] = $urandom;
        scan(1'b1, -1, 10, 1'b0, 0, "abort");
        rst = 1'b1;
        #1;
        check("abort reg_sel", 32'(reg_sel), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort out_idx", 32'(out_idx), 32'd0);
        check("abort out_data", out_data, 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort checksum", checksum, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("after abort no done", 32'(done), 32'd0);
        end
        scan(1'b1, -1, -1, 1'b0, 0, "rescan");

        for (int i = 0; i < N; i++) rf[i] = $urandom;
        scan(1'b0, -1, -1, 1'b1, 3 * N + 1, "hold1");
        scan(1'b0, -1, -1, 1'b1, 3 * N + 1, "hold2");
        start = 1'b0;

        rf[7] = 32'h0000_0048;
        start_b = 1'b1;
        out_ready_b = 1'b1;
        edges = 0;
        seen = 1'b0;
        while (!seen && edges < 50) begin
            if (out_valid_b && out_ready_b) begin
                check("single idx", 32'(out_idx_b), 32'd7);
                check("single data", out_data_b, 32'h0000_0048);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            start_b = 1'b0;
            if (done_b) seen = 1'b1;
        end
        check("single done seen", 32'(seen), 32'd1);
        check("single latency", 32'(edges), 32'd4);
        check("single checksum", checksum_b, 32'h0000_0048);
        @(negedge clk);
        check("single busy after", 32'(busy_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
